// File: rtl/sysid_ext_pkg.sv
// rtl/sysid_ext_pkg.sv - register offsets, CONTROL/STATUS bit indices and offset enum for sysid_ext_regs
package sysid_ext_pkg;

   localparam logic [2:0] ADDR_ID        = 3'd0;
   localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
   localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
   localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
   localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
   localparam logic [2:0] ADDR_CONTROL   = 3'd5;
   localparam logic [2:0] ADDR_STATUS    = 3'd6;
   localparam logic [2:0] ADDR_RSVD      = 3'd7;

   typedef enum logic [2:0] {
      OFF_ID        = ADDR_ID,
      OFF_TIMESTAMP = ADDR_TIMESTAMP,
      OFF_UPTIME_LO = ADDR_UPTIME_LO,
      OFF_UPTIME_HI = ADDR_UPTIME_HI,
      OFF_SCRATCH   = ADDR_SCRATCH,
      OFF_CONTROL   = ADDR_CONTROL,
      OFF_STATUS    = ADDR_STATUS,
      OFF_RSVD      = ADDR_RSVD
   } reg_off_e;

   localparam int CTRL_CLEAR_BIT   = 0;
   localparam int CTRL_FREEZE_BIT  = 1;
   localparam int STAT_WRAPPED_BIT = 0;
   localparam int STAT_FREEZE_BIT  = 1;

   // Wide enough for PRESCALE up to 65535
   localparam int PRESC_W = 16;

endpackage

// File: rtl/sysid_uptime_ctr.sv
// rtl/sysid_uptime_ctr.sv - prescaled free-running uptime counter with sticky wrap flag
// Clear has priority over a coincident tick; freeze only stops the counter, not the prescaler.
module sysid_uptime_ctr
   import sysid_ext_pkg::*;
#(
   parameter int UPTIME_W = 64,
   parameter int PRESCALE = 1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                clear_i,
   input  logic                freeze_i,
   output logic [UPTIME_W-1:0] count_o,
   output logic                wrapped_o
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [UPTIME_W-1:0] count_q, count_d;
   logic                wrapped_q, wrapped_d;
   logic                tick;

   assign tick = (presc_q == PRESC_MAX);

   always_comb begin
      presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
      count_d   = count_q;
      wrapped_d = wrapped_q;
      if (tick && !freeze_i) begin
         count_d = count_q + UPTIME_W'(1);
         if (&count_q) begin
            wrapped_d = 1'b1;
         end
      end
      if (clear_i) begin
         presc_d   = '0;
         count_d   = '0;
         wrapped_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_q   <= '0;
         count_q   <= '0;
         wrapped_q <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         count_q   <= count_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign count_o   = count_q;
   assign wrapped_o = wrapped_q;

endmodule

// File: rtl/sysid_ext_regs.sv
// rtl/sysid_ext_regs.sv - system ID, timestamp, scratch and uptime registers on an Avalon-MM slave
// Uptime counter, UPTIME_HI shadow, CONTROL and STATUS exist only with SYSID_EXT_UPTIME_EN defined.
module sysid_ext_regs
   import sysid_ext_pkg::*;
#(
   parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
   parameter int          UPTIME_W  = 64,
   parameter int          PRESCALE  = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   reg_off_e    off;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rd_mux;

   assign off = reg_off_e'(address);

`ifdef SYSID_EXT_UPTIME_EN
   logic [UPTIME_W-1:0] count;
   logic                wrapped;
   logic                freeze_q, freeze_d;
   logic [31:0]         shadow_q, shadow_d;
   logic                ctrl_wr;
   logic                clear;

   assign ctrl_wr = write && (off == OFF_CONTROL);
   assign clear   = ctrl_wr && writedata[CTRL_CLEAR_BIT];

   sysid_uptime_ctr #(
      .UPTIME_W (UPTIME_W),
      .PRESCALE (PRESCALE)
   ) u_ctr (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear_i   (clear),
      .freeze_i  (freeze_q),
      .count_o   (count),
      .wrapped_o (wrapped)
   );

   // The high half is captured with the low-half read so a 64-bit value is read coherently
   always_comb begin
      freeze_d = freeze_q;
      shadow_d = shadow_q;
      if (ctrl_wr) begin
         freeze_d = writedata[CTRL_FREEZE_BIT];
      end
      if (read && (off == OFF_UPTIME_LO)) begin
         shadow_d = 32'(count[UPTIME_W-1:32]);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         freeze_q <= 1'b0;
         shadow_q <= '0;
      end else begin
         freeze_q <= freeze_d;
         shadow_q <= shadow_d;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{UPTIME_W[0], PRESCALE[0], PRESC_W[0], CTRL_CLEAR_BIT[0],
                         CTRL_FREEZE_BIT[0], STAT_WRAPPED_BIT[0], STAT_FREEZE_BIT[0]};
`endif

   // Mux reads pre-write state, so a same-cycle read/write returns the old value
   always_comb begin
      rd_mux = 32'h0;
      case (off)
         OFF_ID:        rd_mux = ID_VALUE;
         OFF_TIMESTAMP: rd_mux = TIMESTAMP;
         OFF_SCRATCH:   rd_mux = scratch_q;
`ifdef SYSID_EXT_UPTIME_EN
         OFF_UPTIME_LO: rd_mux = count[31:0];
         OFF_UPTIME_HI: rd_mux = shadow_q;
         OFF_STATUS: begin
            rd_mux[STAT_WRAPPED_BIT] = wrapped;
            rd_mux[STAT_FREEZE_BIT]  = freeze_q;
         end
`endif
         default:       rd_mux = 32'h0;
      endcase
   end

   always_comb begin
      scratch_d = scratch_q;
      rdata_d   = rdata_q;
      rvalid_d  = read;
      if (write && (off == OFF_SCRATCH)) begin
         scratch_d = writedata;
      end
      if (read) begin
         rdata_d = rd_mux;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch_q <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
      end else begin
         scratch_q <= scratch_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
      end
   end

   assign readdata      = rdata_q;
   assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_ext_regs.sv
// tb/tb_sysid_ext_regs.sv - scoreboard bench for sysid_ext_regs
// Uptime scenarios are built when SYSID_EXT_UPTIME_EN is defined; otherwise offsets 2, 3, 6 must read 0.
module tb_sysid_ext_regs;

   localparam logic [31:0] ID_VAL = 32'h5B9C_0A7C;
   localparam logic [31:0] TS_VAL = 32'h6655_4433;
   localparam int          UW     = 33;
   localparam int          PS     = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        readdatavalid;

   always #5 clock = ~clock;

   sysid_ext_regs #(
      .ID_VALUE  (ID_VAL),
      .TIMESTAMP (TS_VAL),
      .UPTIME_W  (UW),
      .PRESCALE  (PS)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .readdata      (readdata),
      .readdatavalid (readdatavalid)
   );

   int          n_vec  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   int          t0     = 0;
   logic [31:0] exp_q[$];

   // Posedges since start; (cyc - t0) is the count of edges since the counter last restarted
   always @(posedge clock) cyc <= cyc + 1;

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic idle_until(input int e);
      while ((cyc - t0) < e) @(negedge clock);
   endtask

   task automatic rd(input logic [2:0] a);
      read = 1'b1;
      address = a;
      @(negedge clock);
      read = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      write = 1'b1;
      address = a;
      writedata = d;
      @(negedge clock);
      write = 1'b0;
   endtask

`ifdef SYSID_EXT_UPTIME_EN
   localparam logic [UW-1:0] NEAR = {1'b1, 32'hFFFF_FFFE};

   function automatic logic [31:0] up_lo(input logic [UW-1:0] base, input int e);
      logic [UW-1:0] v;
      v = base + UW'(e / PS);
      return v[31:0];
   endfunction
`endif

   task automatic test_reset();
      n_vec++;
      if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b data=%h, want valid=0 data=00000000", readdatavalid, readdata);
      end
   endtask

`ifdef SYSID_EXT_UPTIME_EN
   task automatic test_uptime_count();
      logic [2:0]  a_t[2] = '{3'd2, 3'd3};
      int          e_t[2] = '{40, 52};
      logic [31:0] exp_v;
      for (int i = 0; i < 2; i++) begin
         idle_until(e_t[i]);
         exp_q.push_back((a_t[i] == 3'd2) ? up_lo('0, cyc - t0) : 32'h0);
         rd(a_t[i]);
         n_vec++;
         exp_v = exp_q.pop_front();
         if (readdatavalid !== 1'b1 || readdata !== exp_v) begin
            n_fail++;
            $display("FAIL uptime_count[%0d]: valid=%b data=%h, want valid=1 data=%h", i, readdatavalid, readdata, exp_v);
         end
      end
   endtask
`endif

   task automatic test_id();
      logic [2:0]  a_t[6] = '{3'd0, 3'd1, 3'd7, 3'd0, 3'd1, 3'd7};
      logic [31:0] c_t[6] = '{ID_VAL, TS_VAL, 32'h0, ID_VAL, TS_VAL, 32'h0};
      logic [31:0] exp_v;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin
            wr(3'd0, 32'hFFFF_FFFF);
            wr(3'd1, 32'h1234_5678);
            wr(3'd7, 32'hA5A5_A5A5);
         end
         exp_q.push_back(c_t[i]);
         rd(a_t[i]);
         n_vec++;
         exp_v = exp_q.pop_front();
         if (readdatavalid !== 1'b1 || readdata !== exp_v) begin
            n_fail++;
            $display("FAIL id_read[%0d]: valid=%b data=%h, want valid=1 data=%h", i, readdatavalid, readdata, exp_v);
         end
      end
   endtask

   task automatic test_scratch();
      logic [31:0] exp_v;
      wr(3'd4, 32'hDEAD_BEEF);
      exp_q.push_back(32'hDEAD_BEEF);
      rd(3'd4);
      n_vec++;
      exp_v = exp_q.pop_front();
      if (readdatavalid !== 1'b1 || readdata !== exp_v) begin
         n_fail++;
         $display("FAIL scratch_rw: valid=%b data=%h, want valid=1 data=%h", readdatavalid, readdata, exp_v);
      end
      // Same-cycle read and write: old value out, new value stored
      read = 1'b1; write = 1'b1; address = 3'd4; writedata = 32'h0BAD_F00D;
      exp_q.push_back(32'hDEAD_BEEF);
      @(negedge clock);
      read = 1'b0; write = 1'b0;
      n_vec++;
      exp_v = exp_q.pop_front();
      if (readdatavalid !== 1'b1 || readdata !== exp_v) begin
         n_fail++;
         $display("FAIL rw_collide: valid=%b data=%h, want valid=1 data=%h", readdatavalid, readdata, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  a_t[3] = '{3'd4, 3'd0, 3'd1};
      logic [31:0] c_t[3] = '{32'h0BAD_F00D, ID_VAL, TS_VAL};
      logic [31:0] exp_v;
      read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         address = a_t[i];
         exp_q.push_back(c_t[i]);
         @(negedge clock);
         if (i == 2) read = 1'b0;
         n_vec++;
         exp_v = exp_q.pop_front();
         if (readdatavalid !== 1'b1 || readdata !== exp_v) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: valid=%b data=%h, want valid=1 data=%h", i, readdatavalid, readdata, exp_v);
         end
      end
      @(negedge clock);
      n_vec++;
      if (readdatavalid !== 1'b0 || readdata !== TS_VAL) begin
         n_fail++;
         $display("FAIL hold_after_read: valid=%b data=%h, want valid=0 data=%h", readdatavalid, readdata, TS_VAL);
      end
   endtask

`ifdef SYSID_EXT_UPTIME_EN
   task automatic test_wrap();
      logic [2:0]  a_t[7] = '{3'd2, 3'd3, 3'd6, 3'd2, 3'd6, 3'd2, 3'd2};
      int          e_t[7] = '{1, 10, 11, 12, 0, 1, 9};
      logic [31:0] c_t[7] = '{32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
      logic [UW-1:0] base;
      logic [31:0] exp_v;
      wr(3'd5, 32'h1);
      t0 = cyc;
      base = NEAR;
      force dut.u_ctr.count_q = NEAR;
      @(negedge clock);
      release dut.u_ctr.count_q;
      for (int i = 0; i < 7; i++) begin
         if (i == 4) begin
            wr(3'd5, 32'h1);
            t0 = cyc;
            base = '0;
         end
         idle_until(e_t[i]);
         exp_q.push_back((a_t[i] == 3'd2) ? up_lo(base, cyc - t0) : c_t[i]);
         rd(a_t[i]);
         n_vec++;
         exp_v = exp_q.pop_front();
         if (readdatavalid !== 1'b1 || readdata !== exp_v) begin
            n_fail++;
            $display("FAIL wrap[%0d] off=%0d: valid=%b data=%h, want valid=1 data=%h", i, a_t[i], readdatavalid, readdata, exp_v);
         end
      end
   endtask

   task automatic test_freeze();
      logic [2:0]    a_t[4] = '{3'd2, 3'd6, 3'd2, 3'd6};
      logic [31:0]   c_t[4] = '{32'h0, 32'h2, 32'h0, 32'h0};
      logic [UW-1:0] frz, v;
      logic [31:0]   exp_v;
      int            e_w, e_r;
      e_r = 0;
      e_w = cyc - t0;
      wr(3'd5, 32'h2);
      frz = UW'((e_w + 1) / PS);
      idle(20);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            e_r = cyc - t0;
            wr(3'd5, 32'h0);
            idle(12);
         end
         v = (i < 2) ? frz : frz + UW'((cyc - t0) / PS - (e_r + 1) / PS);
         exp_q.push_back((a_t[i] == 3'd2) ? v[31:0] : c_t[i]);
         rd(a_t[i]);
         n_vec++;
         exp_v = exp_q.pop_front();
         if (readdatavalid !== 1'b1 || readdata !== exp_v) begin
            n_fail++;
            $display("FAIL freeze[%0d] off=%0d: valid=%b data=%h, want valid=1 data=%h", i, a_t[i], readdatavalid, readdata, exp_v);
         end
      end
   endtask
`else
   task automatic test_no_uptime();
      logic [2:0]  a_t[3] = '{3'd2, 3'd3, 3'd6};
      logic [31:0] exp_v;
      idle(40);
      wr(3'd5, 32'h3);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'h0);
         rd(a_t[i]);
         n_vec++;
         exp_v = exp_q.pop_front();
         if (readdatavalid !== 1'b1 || readdata !== exp_v) begin
            n_fail++;
            $display("FAIL no_uptime off=%0d: valid=%b data=%h, want valid=1 data=%h", a_t[i], readdatavalid, readdata, exp_v);
         end
      end
   endtask
`endif

   task automatic test_reset_pending();
      logic [2:0]  a_t[5] = '{3'd4, 3'd6, 3'd3, 3'd2, 3'd0};
      logic [31:0] c_t[5] = '{32'h0, 32'h0, 32'h0, 32'h0, ID_VAL};
      logic [31:0] exp_v;
      wr(3'd4, 32'h1234_5678);
      wr(3'd5, 32'h2);
      read = 1'b1;
      address = 3'd4;
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      read = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         n_vec++;
         if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pending[%0d]: valid=%b data=%h, want valid=0 data=00000000", i, readdatavalid, readdata);
         end
      end
      reset_n = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(c_t[i]);
         rd(a_t[i]);
         n_vec++;
         exp_v = exp_q.pop_front();
         if (readdatavalid !== 1'b1 || readdata !== exp_v) begin
            n_fail++;
            $display("FAIL post_reset off=%0d: valid=%b data=%h, want valid=1 data=%h", a_t[i], readdatavalid, readdata, exp_v);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      read = 1'b0;
      write = 1'b0;
      address = 3'd0;
      writedata = 32'h0;
      idle(3);
      test_reset();
      reset_n = 1'b1;
      t0 = cyc;
`ifdef SYSID_EXT_UPTIME_EN
      test_uptime_count();
`endif
      test_id();
      test_scratch();
      test_back_to_back();
`ifdef SYSID_EXT_UPTIME_EN
      test_wrap();
      test_freeze();
`else
      test_no_uptime();
`endif
      test_reset_pending();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sysid_ext_regs.md
SYSID_EXT_REGS -- requirements
Module: sysid_ext_regs

Interface
REQ-001 Parameter ID_VALUE, default 32'h0000_0000, system ID word returned at offset 0.
REQ-002 Parameter TIMESTAMP, default 32'h0000_0000, build timestamp returned at offset 1.
REQ-003 Parameter UPTIME_W, default 64, uptime counter width; legal range 33..64.
REQ-004 Parameter PRESCALE, default 1, clock cycles per uptime tick; legal range 1..65535.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 address  in  3  word offset, Avalon-MM slave.
REQ-008 read  in  1  read strobe, one cycle per transfer.
REQ-009 write  in  1  write strobe, one cycle per transfer.
REQ-010 writedata  in  32  write data.
REQ-011 readdata  out  32  registered read data.
REQ-012 readdatavalid  out  1  high exactly one cycle, qualifying readdata.

Function
REQ-013 Register map: 0 ID (RO), 1 TIMESTAMP (RO), 2 UPTIME_LO (RO), 3 UPTIME_HI (RO, shadow), 4 SCRATCH (RW), 5 CONTROL (WO), 6 STATUS (RO), 7 reserved (reads 0).
REQ-014 Fixed read latency of 1: read at cycle N gives readdatavalid=1 and readdata at cycle N+1; no waitrequest.
REQ-015 readdata holds its last value while readdatavalid=0.
REQ-016 Prescaler counts 0..PRESCALE-1 and wraps; the uptime counter increments by 1 on each wrap unless frozen.
REQ-017 Uptime counter wraps from all-ones to 0 and sets the sticky STATUS bit0 (WRAPPED).
REQ-018 Reading UPTIME_LO returns counter bits [31:0] and, in the same cycle, latches bits [UPTIME_W-1:32] (zero-extended) into the UPTIME_HI shadow.
REQ-019 Reading UPTIME_HI returns the shadow and never the live counter.
REQ-020 CONTROL write: bit0=1 clears the counter, prescaler and WRAPPED (self-clearing); bit1 sets FREEZE to the written value; other bits are ignored.
REQ-021 If a clear and a tick coincide, the clear wins and the counter is 0 on the next cycle.
REQ-022 STATUS: bit0 WRAPPED, bit1 FREEZE, bits[31:2] are 0.
REQ-023 SCRATCH stores all 32 bits of writedata on a write.
REQ-024 Writes to RO or reserved offsets have no effect.
REQ-025 With read and write asserted in the same cycle at the same offset, the read returns the pre-write value and the write takes effect.

Reset
REQ-026 On reset_n low, immediately: readdata=0, readdatavalid=0, counter=0, prescaler=0, shadow=0, SCRATCH=0, FREEZE=0, WRAPPED=0.
REQ-027 Reset asserted while a read is pending drops readdatavalid with no response; deassertion is synchronised externally.

Configuration
REQ-028 With macro SYSID_EXT_UPTIME_EN defined, the prescaler, counter, shadow, CONTROL and STATUS are implemented as specified.
REQ-029 Without SYSID_EXT_UPTIME_EN, no counter logic is synthesised, offsets 2, 3 and 6 read 0, and CONTROL writes are ignored; ID, TIMESTAMP, SCRATCH and timing are unchanged.

Structure
REQ-030 Package sysid_ext_pkg holds the register offset constants, CONTROL/STATUS bit indices and an enumerated offset type.
REQ-031 Sub-module sysid_uptime_ctr holds the prescaler, counter, wrap flag and freeze/clear inputs; the top level holds decode, scratch, shadow and read pipeline.

Verification
REQ-032 Bench: ID_VALUE=32'h5B9C_0A7C, read offsets 0 and 1 -> readdatavalid one cycle later with the parameter values; offset 7 -> 0.
REQ-033 Bench: write 32'hDEAD_BEEF to offset 4, then read it back -> 32'hDEAD_BEEF; write to offset 0 -> a later read still returns ID_VALUE.
REQ-034 Bench: PRESCALE=4 after reset, idle 40 cycles, read offset 2 -> 10 (±1 depending on read-cycle alignment); a read of offset 3 after further ticks returns the shadow latched at the offset 2 read.
REQ-035 Bench: UPTIME_W=33 with counter forced near all-ones -> after wrap, offset 2 reads a small value and offset 6 bit0=1; CONTROL write 1 -> offset 6 bit0=0 and the counter restarts from 0.
REQ-036 Bench: CONTROL write 2 (freeze), wait 20 cycles -> offset 2 unchanged and offset 6 = 2; write 0 -> counting resumes.
REQ-037 Bench: assert reset_n low in the cycle after a read -> no readdatavalid, and all registers read their reset values after release.
